// File: rtl/fpu_issue_ctrl.sv
// Issue/return controller for a stall-less FPU pipe: credit-limited issue, tag pairing, writeback buffer.
// Defining FPU_ISSUE_CTRL_STATS_EN adds the stat_issued/stat_stall/stat_wb_block counters.
module fpu_issue_ctrl #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_x,
   input  logic [31:0]      req_y,
   input  logic [4:0]       req_funct5,
   input  logic [2:0]       req_rm,
   input  logic [TAG_W-1:0] req_tag,
   output logic             fpu_issue,
   output logic [31:0]      fpu_x,
   output logic [31:0]      fpu_y,
   output logic [4:0]       fpu_funct5,
   output logic [2:0]       fpu_rm,
   input  logic [31:0]      fpu_res,
   input  logic             fpu_valid,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [31:0]      wb_data,
   output logic [TAG_W-1:0] wb_tag,
   output logic             err
`ifdef FPU_ISSUE_CTRL_STATS_EN
   ,
   output logic [31:0]      stat_issued,
   output logic [31:0]      stat_stall,
   output logic [31:0]      stat_wb_block
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int RW = TAG_W + 32;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] C_ONE   = CW'(1);
   localparam logic [PW-1:0] P_ONE   = PW'(1);

   logic [CW-1:0]    occ_q, occ_d;
   logic [CW-1:0]    tag_cnt_q, tag_cnt_d;
   logic [CW-1:0]    res_cnt_q, res_cnt_d;
   logic [PW-1:0]    tag_wp_q, tag_rp_q;
   logic [PW-1:0]    res_wp_q, res_rp_q;
   logic             rdy_en_q;
   logic             err_q;
   logic             fpu_issue_q;
   logic [31:0]      fpu_x_q, fpu_y_q;
   logic [4:0]       fpu_funct5_q;
   logic [2:0]       fpu_rm_q;

   logic [TAG_W-1:0] tag_mem [DEPTH];
   logic [RW-1:0]    res_mem [DEPTH];
   logic [RW-1:0]    res_head;

   logic             accept, wb_pop, ret_ok, ret_bad;

   // rdy_en_q keeps req_ready low through reset and rises on the first edge after release.
   assign req_ready = rdy_en_q && (occ_q < DEPTH_C);
   assign accept    = req_valid && req_ready;
   assign wb_valid  = (res_cnt_q != '0);
   assign wb_pop    = wb_valid && wb_ready;
   assign ret_ok    = fpu_valid && (tag_cnt_q != '0);
   assign ret_bad   = fpu_valid && (tag_cnt_q == '0);

   assign res_head  = res_mem[res_rp_q];
   assign wb_data   = wb_valid ? res_head[31:0] : '0;
   assign wb_tag    = wb_valid ? res_head[RW-1:32] : '0;

   assign fpu_issue  = fpu_issue_q;
   assign fpu_x      = fpu_x_q;
   assign fpu_y      = fpu_y_q;
   assign fpu_funct5 = fpu_funct5_q;
   assign fpu_rm     = fpu_rm_q;
   assign err        = err_q;

   always_comb begin
      occ_d     = occ_q;
      tag_cnt_d = tag_cnt_q;
      res_cnt_d = res_cnt_q;
      case ({accept, wb_pop})
         2'b10:   occ_d = occ_q + C_ONE;
         2'b01:   occ_d = occ_q - C_ONE;
         default: occ_d = occ_q;
      endcase
      case ({accept, ret_ok})
         2'b10:   tag_cnt_d = tag_cnt_q + C_ONE;
         2'b01:   tag_cnt_d = tag_cnt_q - C_ONE;
         default: tag_cnt_d = tag_cnt_q;
      endcase
      case ({ret_ok, wb_pop})
         2'b10:   res_cnt_d = res_cnt_q + C_ONE;
         2'b01:   res_cnt_d = res_cnt_q - C_ONE;
         default: res_cnt_d = res_cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rdy_en_q     <= 1'b0;
         occ_q        <= '0;
         tag_cnt_q    <= '0;
         res_cnt_q    <= '0;
         tag_wp_q     <= '0;
         tag_rp_q     <= '0;
         res_wp_q     <= '0;
         res_rp_q     <= '0;
         err_q        <= 1'b0;
         fpu_issue_q  <= 1'b0;
         fpu_x_q      <= '0;
         fpu_y_q      <= '0;
         fpu_funct5_q <= '0;
         fpu_rm_q     <= '0;
      end else begin
         rdy_en_q    <= 1'b1;
         occ_q       <= occ_d;
         tag_cnt_q   <= tag_cnt_d;
         res_cnt_q   <= res_cnt_d;
         fpu_issue_q <= accept;
         if (accept) begin
            tag_wp_q     <= tag_wp_q + P_ONE;
            fpu_x_q      <= req_x;
            fpu_y_q      <= req_y;
            fpu_funct5_q <= req_funct5;
            fpu_rm_q     <= req_rm;
         end
         if (ret_ok) begin
            tag_rp_q <= tag_rp_q + P_ONE;
            res_wp_q <= res_wp_q + P_ONE;
         end
         if (wb_pop) res_rp_q <= res_rp_q + P_ONE;
         if (ret_bad) err_q <= 1'b1;
      end
   end

   // FIFO storage carries data only; occupancy lives in the counters above.
   always_ff @(posedge clk) begin
      if (accept) tag_mem[tag_wp_q] <= req_tag;
      if (ret_ok) res_mem[res_wp_q] <= {tag_mem[tag_rp_q], fpu_res};
   end

`ifdef FPU_ISSUE_CTRL_STATS_EN
   logic [31:0] st_iss_q, st_stall_q, st_wbb_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         st_iss_q   <= '0;
         st_stall_q <= '0;
         st_wbb_q   <= '0;
      end else begin
         if (accept)                  st_iss_q   <= st_iss_q + 32'd1;
         if (req_valid && !req_ready) st_stall_q <= st_stall_q + 32'd1;
         if (wb_valid && !wb_ready)   st_wbb_q   <= st_wbb_q + 32'd1;
      end
   end

   assign stat_issued   = st_iss_q;
   assign stat_stall    = st_stall_q;
   assign stat_wb_block = st_wbb_q;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: queue-based reference model plus an in-order FPU pipe model.
module tb_fpu_issue_ctrl;
   localparam int DEPTH = 4;
   localparam int TAG_W = 5;

   logic             clk = 1'b0;
   logic             rstn;
   logic             req_valid, req_ready;
   logic [31:0]      req_x, req_y;
   logic [4:0]       req_funct5;
   logic [2:0]       req_rm;
   logic [TAG_W-1:0] req_tag;
   logic             fpu_issue;
   logic [31:0]      fpu_x, fpu_y;
   logic [4:0]       fpu_funct5;
   logic [2:0]       fpu_rm;
   logic [31:0]      fpu_res;
   logic             fpu_valid;
   logic             wb_valid, wb_ready;
   logic [31:0]      wb_data;
   logic [TAG_W-1:0] wb_tag;
   logic             err;

   always #5 clk = ~clk;

   fpu_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
      .req_funct5(req_funct5), .req_rm(req_rm), .req_tag(req_tag),
      .fpu_issue(fpu_issue), .fpu_x(fpu_x), .fpu_y(fpu_y), .fpu_funct5(fpu_funct5),
      .fpu_rm(fpu_rm), .fpu_res(fpu_res), .fpu_valid(fpu_valid),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_tag(wb_tag),
      .err(err)
   );

   int n_chk = 0;
   int n_pass = 0;

   typedef struct { logic [TAG_W-1:0] tag; logic [31:0] data; } res_t;
   typedef struct { int due; logic [31:0] res; } pipe_t;

   // Reference model: outstanding tags, buffered results, occupancy.
   logic [TAG_W-1:0] m_tagq[$];
   res_t             m_resq[$];
   int               m_occ;
   bit               m_rdy_en, m_err, m_acc;
   logic             m_iss;
   logic [31:0]      m_x, m_y;
   logic [4:0]       m_f5;
   logic [2:0]       m_rm;

   // In-order FPU pipe model.
   pipe_t sched[$];
   int    last_due, cyc, pipe_lat;
   bit    pipe_en;

   function automatic bit m_ready();
      return m_rdy_en && (m_occ < DEPTH);
   endfunction

   function automatic logic [31:0] fpu_fn(logic [31:0] x, logic [31:0] y, logic [4:0] f, logic [2:0] r);
      return (x + y) ^ {24'd0, f, r};
   endfunction

   task automatic model_reset();
      m_tagq.delete(); m_resq.delete(); sched.delete();
      m_occ = 0; m_rdy_en = 0; m_err = 0; m_acc = 0; last_due = 0;
      m_iss = 0; m_x = 0; m_y = 0; m_f5 = 0; m_rm = 0;
   endtask

   task automatic rand_req(input logic [TAG_W-1:0] tag);
      req_x = $urandom; req_y = $urandom;
      req_funct5 = 5'($urandom_range(0, 31)); req_rm = 3'($urandom_range(0, 7));
      req_tag = tag;
   endtask

   // One clock: update the model from the inputs about to be sampled, advance to the next negedge, run the pipe.
   task automatic tick();
      bit    pop;
      res_t  r;
      pipe_t p;
      if (rstn) begin
         m_acc = req_valid && m_ready();
         pop = (m_resq.size() > 0) && wb_ready;
         if (pop) void'(m_resq.pop_front());
         if (fpu_valid) begin
            if (m_tagq.size() > 0) begin
               r.tag = m_tagq.pop_front(); r.data = fpu_res; m_resq.push_back(r);
            end else m_err = 1;
         end
         if (m_acc) begin
            m_tagq.push_back(req_tag);
            m_x = req_x; m_y = req_y; m_f5 = req_funct5; m_rm = req_rm;
         end
         m_iss = m_acc;
         m_occ = m_occ + int'(m_acc) - int'(pop);
         m_rdy_en = 1;
      end else m_acc = 0;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (pipe_en && rstn) begin
         if (fpu_issue === 1'b1) begin
            p.due = (cyc + pipe_lat > last_due + 1) ? cyc + pipe_lat : last_due + 1;
            p.res = fpu_fn(fpu_x, fpu_y, fpu_funct5, fpu_rm);
            last_due = p.due;
            sched.push_back(p);
         end
         if (sched.size() > 0 && sched[0].due == cyc) begin
            fpu_valid = 1'b1; fpu_res = sched[0].res; void'(sched.pop_front());
         end else begin
            fpu_valid = 1'b0; fpu_res = $urandom;
         end
      end
   endtask

   task automatic drain(output bit ok);
      req_valid = 0; wb_ready = 1;
      for (int i = 0; i < 60 && (m_occ != 0 || sched.size() != 0); i++) tick();
      ok = (m_occ == 0 && sched.size() == 0);
   endtask

   task automatic test_reset();
      rstn = 0; pipe_en = 0; req_valid = 1; wb_ready = 1; fpu_valid = 1; fpu_res = $urandom;
      rand_req(5'd7);
      model_reset();
      repeat (2) tick();
      n_chk++; if ({req_ready, fpu_issue, wb_valid, err} !== 4'b0) $display("FAIL rst_ctrl got=%b exp=0000", {req_ready, fpu_issue, wb_valid, err}); else n_pass++;
      n_chk++; if ({fpu_x, fpu_y, fpu_funct5, fpu_rm} !== 72'd0) $display("FAIL rst_fpu got=%h exp=0", {fpu_x, fpu_y, fpu_funct5, fpu_rm}); else n_pass++;
      n_chk++; if ({wb_data, wb_tag} !== '0) $display("FAIL rst_wb got=%h exp=0", {wb_data, wb_tag}); else n_pass++;
      req_valid = 0; fpu_valid = 0; rstn = 1;
      n_chk++; if (req_ready !== 1'b0) $display("FAIL rst_rel_ready got=%b exp=0", req_ready); else n_pass++;
      tick();
      n_chk++; if (req_ready !== 1'b1) $display("FAIL rst_rise_ready got=%b exp=1", req_ready); else n_pass++;
   endtask

   task automatic test_fadd();
      pipe_en = 0; wb_ready = 0; fpu_valid = 0;
      req_valid = 1; req_x = 32'h3F800000; req_y = 32'h40000000; req_funct5 = 0; req_rm = 0; req_tag = 3;
      tick();
      req_valid = 0;
      n_chk++; if (fpu_issue !== 1'b1) $display("FAIL fadd_issue got=%b exp=1", fpu_issue); else n_pass++;
      n_chk++; if ({fpu_x, fpu_y, fpu_funct5, fpu_rm} !== {32'h3F800000, 32'h40000000, 8'd0}) $display("FAIL fadd_ops got=%h/%h exp=3f800000/40000000", fpu_x, fpu_y); else n_pass++;
      tick();
      n_chk++; if ({fpu_issue, fpu_x} !== {1'b0, 32'h3F800000}) $display("FAIL fadd_hold got=%b/%h exp=0/3f800000", fpu_issue, fpu_x); else n_pass++;
      fpu_valid = 1; fpu_res = 32'h40400000;
      n_chk++; if (wb_valid !== 1'b0) $display("FAIL fadd_wb_early got=%b exp=0", wb_valid); else n_pass++;
      tick();
      fpu_valid = 0;
      n_chk++; if ({wb_valid, wb_data, wb_tag} !== {1'b1, 32'h40400000, 5'd3}) $display("FAIL fadd_wb got=%b/%h/%0d exp=1/40400000/3", wb_valid, wb_data, wb_tag); else n_pass++;
      tick();
      n_chk++; if ({wb_valid, wb_data, wb_tag} !== {1'b1, 32'h40400000, 5'd3}) $display("FAIL fadd_wb_stable got=%b/%h/%0d exp=1/40400000/3", wb_valid, wb_data, wb_tag); else n_pass++;
      wb_ready = 1; tick(); wb_ready = 0;
      n_chk++; if (wb_valid !== 1'b0) $display("FAIL fadd_wb_pop got=%b exp=0", wb_valid); else n_pass++;
   endtask

   task automatic test_backpressure();
      int k;
      pipe_en = 1; pipe_lat = 2; wb_ready = 0;
      for (int t = 1; t <= 4; t++) begin
         req_valid = 1; rand_req(TAG_W'(t));
         n_chk++; if (req_ready !== 1'b1) $display("FAIL bp_ready t=%0d got=%b exp=1", t, req_ready); else n_pass++;
         tick();
      end
      rand_req(5'd5);
      for (int i = 0; i < 6; i++) begin
         n_chk++; if (req_ready !== 1'b0) $display("FAIL bp_stall i=%0d got=%b exp=0", i, req_ready); else n_pass++;
         tick();
      end
      n_chk++; if ({wb_valid, wb_tag} !== {1'b1, 5'd1}) $display("FAIL bp_head got=%b/%0d exp=1/1", wb_valid, wb_tag); else n_pass++;
      wb_ready = 1; tick(); wb_ready = 0;
      n_chk++; if (req_ready !== 1'b1) $display("FAIL bp_reopen got=%b exp=1", req_ready); else n_pass++;
      tick();
      req_valid = 0;
      n_chk++; if (req_ready !== 1'b0) $display("FAIL bp_refull got=%b exp=0", req_ready); else n_pass++;
      wb_ready = 1; k = 2;
      for (int c = 0; c < 40 && k <= 5; c++) begin
         if (wb_valid === 1'b1) begin
            n_chk++; if (wb_tag !== TAG_W'(k)) $display("FAIL bp_order got=%0d exp=%0d", wb_tag, k); else n_pass++;
            k++;
         end
         tick();
      end
      n_chk++; if (k != 6) $display("FAIL bp_drain got=%0d exp=6", k); else n_pass++;
   endtask

   task automatic test_streaming();
      bit ok;
      drain(ok);
      n_chk++; if (!ok) $display("FAIL st_drain got=%0d exp=0", m_occ); else n_pass++;
      pipe_lat = 1; wb_ready = 1;
      for (int c = 0; c < 30; c++) begin
         req_valid = 1; rand_req(TAG_W'(c));
         if (c >= 4) begin
            n_chk++;
            if ({req_ready, wb_valid, wb_tag} !== {2'b11, TAG_W'(c - 3)})
               $display("FAIL st_flow c=%0d got=%b%b/%0d exp=11/%0d", c, req_ready, wb_valid, wb_tag, (c - 3) % 32);
            else n_pass++;
         end
         tick();
      end
      req_valid = 0;
   endtask

   task automatic test_full_simul();
      bit ok;
      drain(ok);
      n_chk++; if (!ok) $display("FAIL sim_drain got=%0d exp=0", m_occ); else n_pass++;
      pipe_lat = 1; wb_ready = 0; req_valid = 1;
      for (int t = 0; t < 4; t++) begin rand_req(TAG_W'(8 + t)); tick(); end
      rand_req(5'd12);
      repeat (4) tick();
      n_chk++; if (req_ready !== 1'b0) $display("FAIL sim_full got=%b exp=0", req_ready); else n_pass++;
      wb_ready = 1; tick();
      n_chk++; if (req_ready !== 1'b1) $display("FAIL sim_after_wb got=%b exp=1", req_ready); else n_pass++;
      tick();
      n_chk++; if (req_ready !== 1'b1) $display("FAIL sim_acc_wb got=%b exp=1", req_ready); else n_pass++;
      wb_ready = 0; rand_req(5'd13); tick();
      req_valid = 0;
      n_chk++; if (req_ready !== 1'b0) $display("FAIL sim_acc_only got=%b exp=0", req_ready); else n_pass++;
   endtask

   task automatic test_random();
      bit pend = 0;
      int wb_pct = 70;
      pipe_en = 1;
      for (int c = 0; c < 400; c++) begin
         if (c % 50 == 0) begin pipe_lat = $urandom_range(1, 4); wb_pct = $urandom_range(10, 100); end
         if (!pend) begin req_valid = ($urandom_range(0, 3) != 0); rand_req(TAG_W'($urandom_range(0, 31))); end
         wb_ready = ($urandom_range(0, 99) < wb_pct);
         n_chk++; if (req_ready !== m_ready()) $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, m_ready()); else n_pass++;
         n_chk++; if (wb_valid !== (m_resq.size() > 0)) $display("FAIL rnd_wb_valid c=%0d got=%b exp=%b", c, wb_valid, m_resq.size() > 0); else n_pass++;
         if (m_resq.size() > 0) begin
            n_chk++;
            if ({wb_tag, wb_data} !== {m_resq[0].tag, m_resq[0].data}) $display("FAIL rnd_wb_head c=%0d got=%0d/%h exp=%0d/%h", c, wb_tag, wb_data, m_resq[0].tag, m_resq[0].data);
            else n_pass++;
         end
         n_chk++; if (fpu_issue !== m_iss) $display("FAIL rnd_issue c=%0d got=%b exp=%b", c, fpu_issue, m_iss); else n_pass++;
         n_chk++; if ({fpu_x, fpu_y, fpu_funct5, fpu_rm} !== {m_x, m_y, m_f5, m_rm}) $display("FAIL rnd_ops c=%0d got=%h/%h exp=%h/%h", c, fpu_x, fpu_y, m_x, m_y); else n_pass++;
         n_chk++; if (err !== m_err) $display("FAIL rnd_err c=%0d got=%b exp=%b", c, err, m_err); else n_pass++;
         tick();
         pend = req_valid && !m_acc;
      end
      req_valid = 0;
   endtask

   task automatic test_err();
      bit ok;
      drain(ok);
      n_chk++; if (!ok) $display("FAIL err_drain got=%0d exp=0", m_occ); else n_pass++;
      pipe_en = 0; wb_ready = 1;
      fpu_valid = 1; fpu_res = $urandom;
      n_chk++; if (err !== 1'b0) $display("FAIL err_pre got=%b exp=0", err); else n_pass++;
      tick();
      fpu_valid = 0;
      n_chk++; if ({err, wb_valid} !== 2'b10) $display("FAIL err_set got=%b/%b exp=1/0", err, wb_valid); else n_pass++;
      repeat (10) tick();
      n_chk++; if ({err, wb_valid} !== 2'b10) $display("FAIL err_sticky got=%b/%b exp=1/0", err, wb_valid); else n_pass++;
   endtask

   task automatic test_reset_midop();
      logic [31:0] ex;
      bit seen = 0;
      pipe_en = 1; pipe_lat = 6; wb_ready = 0;
      for (int i = 0; i < 3; i++) begin req_valid = 1; rand_req(TAG_W'(20 + i)); tick(); end
      req_valid = 0;
      tick();
      rstn = 0; pipe_en = 0; model_reset();
      #1;
      n_chk++; if ({req_ready, fpu_issue, wb_valid, err} !== 4'b0) $display("FAIL mid_ctrl got=%b exp=0000", {req_ready, fpu_issue, wb_valid, err}); else n_pass++;
      n_chk++; if ({fpu_x, fpu_y, fpu_funct5, fpu_rm, wb_data, wb_tag} !== '0) $display("FAIL mid_data got=%h exp=0", {fpu_x, wb_data}); else n_pass++;
      fpu_valid = 1; fpu_res = $urandom; req_valid = 1;
      repeat (3) tick();
      rstn = 1; fpu_valid = 0; req_valid = 0;
      n_chk++; if ({req_ready, wb_valid} !== 2'b00) $display("FAIL mid_rel got=%b exp=00", {req_ready, wb_valid}); else n_pass++;
      tick();
      n_chk++; if ({req_ready, wb_valid, err} !== 3'b100) $display("FAIL mid_after got=%b exp=100", {req_ready, wb_valid, err}); else n_pass++;
      pipe_en = 1; pipe_lat = 2;
      req_valid = 1; rand_req(5'd9);
      ex = fpu_fn(req_x, req_y, req_funct5, req_rm);
      tick();
      req_valid = 0;
      for (int c = 0; c < 12 && !seen; c++) begin
         if (wb_valid === 1'b1) seen = 1; else tick();
      end
      n_chk++; if ({seen, wb_tag, wb_data} !== {1'b1, 5'd9, ex}) $display("FAIL mid_new got=%b/%0d/%h exp=1/9/%h", seen, wb_tag, wb_data, ex); else n_pass++;
   endtask

   initial begin
      rstn = 0; req_valid = 0; wb_ready = 0; fpu_valid = 0; fpu_res = 0;
      req_x = 0; req_y = 0; req_funct5 = 0; req_rm = 0; req_tag = 0;
      pipe_en = 0; pipe_lat = 1; cyc = 0;
      model_reset();
      test_reset();
      test_fadd();
      test_backpressure();
      test_streaming();
      test_full_simul();
      test_random();
      test_err();
      test_reset_midop();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time=%0t exp=finish", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
